key_debounce_mc: RTL and testbench
==================================

KEY_DEBOUNCE_MC -- requirements
Module: key_debounce_mc

Interface
REQ-001 SHALL have parameter KEY_NUM, default 4: number of independent key channels (≥1).
REQ-002 SHALL have parameter CNT_MAX, default 999_999: debounce window in clock cycles (≥1).
REQ-003 SHALL have parameter LONG_MAX, default 49_999_999: long-press threshold in cycles after press acceptance (≥1).
REQ-004 SHALL have parameter ACTIVE_LOW, default 1: 1 = pressed key reads 0; 0 = pressed key reads 1.
REQ-005 SHALL have port sys_clk, input, 1: sole clock, all logic on rising edge.
REQ-006 SHALL have port sys_rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port key_in, input, KEY_NUM: raw asynchronous key levels.
REQ-008 SHALL have port key_press, output, KEY_NUM: one-cycle pulse per accepted press.
REQ-009 SHALL have port key_release, output, KEY_NUM: one-cycle pulse per accepted release.
REQ-010 SHALL have port key_long, output, KEY_NUM: one-cycle pulse when a press has been held LONG_MAX cycles.
REQ-011 SHALL have port key_state, output, KEY_NUM: debounced level, 1 = pressed.

Function
REQ-012 Each channel SHALL be fully independent, with its own synchroniser, FSM, debounce counter, hold counter.
REQ-013 Each key_in bit SHALL pass a 2-flop synchroniser; r = synchronised value, inverted when ACTIVE_LOW=1 (r=1 means pressed).
REQ-014 Per-channel FSM states: IDLE, DB_DOWN, PRESSED, DB_UP.
REQ-015 IDLE: r=1 -> DB_DOWN with debounce count 0; else stay.
REQ-016 DB_DOWN: r=0 -> IDLE, count cleared; count==CNT_MAX-1 with r=1 -> PRESSED, key_press pulse; else count+1.
REQ-017 PRESSED: r=0 -> DB_UP with count 0; else stay; hold counter increments each cycle.
REQ-018 DB_UP: r=1 -> PRESSED, count cleared; count==CNT_MAX-1 with r=0 -> IDLE, key_release pulse, hold counter cleared; else count+1; hold counter frozen.
REQ-019 Latency: counting the first edge sampling key_in active (stable) as edge 0, key_press SHALL be high in the cycle after edge CNT_MAX+2; key_release likewise relative to key_in becoming stably inactive.
REQ-020 Hold counter SHALL start at 0 on entering PRESSED from DB_DOWN; when it equals LONG_MAX-1 it SHALL pulse key_long and saturate at LONG_MAX; key_long rises exactly LONG_MAX cycles after key_press.
REQ-021 key_long SHALL pulse at most once per accepted press, including across DB_UP bounces back into PRESSED.
REQ-022 key_state SHALL be 1 in PRESSED and DB_UP, 0 in IDLE and DB_DOWN.
REQ-023 key_press, key_release, key_long SHALL be registered; never high two consecutive cycles; press/release never simultaneous on one channel.
REQ-024 Counter widths SHALL be $clog2-derived to hold CNT_MAX and LONG_MAX without wrap; no counter shall wrap.
REQ-025 A glitch shorter than the full window SHALL restart counting; no partial credit is retained.

Reset
REQ-026 On sys_rst_n=0, immediately and independent of sys_clk: all FSMs IDLE, all counters 0, all outputs 0.
REQ-027 Synchroniser flops SHALL reset to the inactive level (1 if ACTIVE_LOW=1, else 0), so a key held through reset needs a full window before key_press.
REQ-028 Reset asserted mid-operation SHALL discard debounce/hold progress; no release pulse generated.

Verification (KEY_NUM=2, CNT_MAX=4, LONG_MAX=10, ACTIVE_LOW=1)
REQ-029 Clean press: key_in[0] 1->0 held from edge 0 -> key_press[0]=1 only in cycle after edge 6; key_state[0]=1 from then; channel 1 outputs stay 0.
REQ-030 Bounce: key_in[0] low 3 cycles, high 1, then low held -> no pulse during bounce; key_press[0] 6 edges after final falling sample.
REQ-031 Long hold: key_in[0] low 30 cycles -> one key_press, one key_long exactly 10 cycles later, no second key_long.
REQ-032 Short press + release: low 12 cycles then high -> key_press, no key_long, key_release after edge 6 counted from first high sample; key_state returns 0 same cycle.
REQ-033 Reset mid-DB_DOWN: assert reset 2 cycles after key_in[0] falls, release with key held -> outputs 0 during reset; key_press[0] 6 edges after first post-reset edge.
REQ-034 Concurrency: both keys pressed, ch1 one cycle later -> key_press[0] and key_press[1] each once, one cycle apart.

Source files
------------

// File: rtl/key_debounce_mc.sv
// rtl/key_debounce_mc.sv - multi-channel key debouncer with press/release/long-press pulses
//
// Purpose:
//   KEY_NUM independent key channels. Each raw key level is brought into the
//   sys_clk domain by a 2-flop synchroniser. It is then filtered by a
//   four-state FSM (IDLE, DB_DOWN, PRESSED, DB_UP). A level change is accepted
//   only after it has been seen stable for a full debounce window.
//
// Ports:
//   sys_clk      in   1        sole clock, rising edge
//   sys_rst_n    in   1        asynchronous active-low reset
//   key_in       in   KEY_NUM  raw asynchronous key levels
//   key_press    out  KEY_NUM  one-cycle pulse per accepted press
//   key_release  out  KEY_NUM  one-cycle pulse per accepted release
//   key_long     out  KEY_NUM  one-cycle pulse once a press has been held LONG_MAX cycles
//   key_state    out  KEY_NUM  debounced level, 1 = pressed

module key_debounce_mc #(
    parameter int KEY_NUM    = 4,
    parameter int CNT_MAX    = 999_999,
    parameter int LONG_MAX   = 49_999_999,
    parameter int ACTIVE_LOW = 1
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic [KEY_NUM-1:0] key_in,
    output logic [KEY_NUM-1:0] key_press,
    output logic [KEY_NUM-1:0] key_release,
    output logic [KEY_NUM-1:0] key_long,
    output logic [KEY_NUM-1:0] key_state
);

    localparam int CW = $clog2(CNT_MAX + 1);
    localparam int HW = $clog2(LONG_MAX + 1);

    localparam logic [CW-1:0] CNT_LAST  = CW'(CNT_MAX - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_MAX - 1);
    localparam logic [HW-1:0] HOLD_SAT  = HW'(LONG_MAX);

    // Raw level of a released key; the synchroniser resets to it so a key
    // held through reset still has to earn a full debounce window.
    localparam logic INACTIVE = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DB_DOWN = 2'd1,
        PRESSED = 2'd2,
        DB_UP   = 2'd3
    } state_t;

    for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
        logic          sync1;
        logic          sync2;
        logic          r;
        state_t        state;
        logic [CW-1:0] cnt;
        logic [HW-1:0] hold;
        logic          press_q;
        logic          release_q;
        logic          long_q;
        logic          state_q;

        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                sync1 <= INACTIVE;
                sync2 <= INACTIVE;
            end else begin
                sync1 <= key_in[i];
                sync2 <= sync1;
            end
        end

        // r = 1 means "pressed" regardless of the key's electrical polarity.
        assign r = (ACTIVE_LOW != 0) ? ~sync2 : sync2;

        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                state     <= IDLE;
                cnt       <= '0;
                hold      <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
                state_q   <= 1'b0;
            end else begin
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;

                // The hold counter runs only in PRESSED and saturates at
                // LONG_MAX, so key_long can fire only once per accepted press,
                // even when DB_UP bounces back into PRESSED.
                if (state == PRESSED) begin
                    if (hold == HOLD_LAST) begin
                        long_q <= 1'b1;
                        hold   <= HOLD_SAT;
                    end else if (hold != HOLD_SAT) begin
                        hold <= hold + HW'(1);
                    end
                end

                case (state)
                    IDLE: begin
                        if (r) begin
                            state <= DB_DOWN;
                            cnt   <= '0;
                        end
                    end
                    DB_DOWN: begin
                        if (!r) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else if (cnt == CNT_LAST) begin
                            state   <= PRESSED;
                            cnt     <= '0;
                            hold    <= '0;
                            press_q <= 1'b1;
                            state_q <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    PRESSED: begin
                        if (!r) begin
                            state <= DB_UP;
                            cnt   <= '0;
                        end
                    end
                    DB_UP: begin
                        if (r) begin
                            state <= PRESSED;
                            cnt   <= '0;
                        end else if (cnt == CNT_LAST) begin
                            state     <= IDLE;
                            cnt       <= '0;
                            hold      <= '0;
                            release_q <= 1'b1;
                            state_q   <= 1'b0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        cnt     <= '0;
                        hold    <= '0;
                        state_q <= 1'b0;
                    end
                endcase
            end
        end

        assign key_press[i]   = press_q;
        assign key_release[i] = release_q;
        assign key_long[i]    = long_q;
        assign key_state[i]   = state_q;
    end

endmodule

// File: tb/tb_key_debounce_mc.sv
// tb/tb_key_debounce_mc.sv - self-checking bench for key_debounce_mc

module tb_key_debounce_mc;

    localparam int KN = 2;
    localparam int CM = 4;
    localparam int LM = 10;

    logic          sys_clk   = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic [KN-1:0] key_in    = '1;
    logic [KN-1:0] key_press;
    logic [KN-1:0] key_release;
    logic [KN-1:0] key_long;
    logic [KN-1:0] key_state;

    int checks = 0;
    int errors = 0;

    key_debounce_mc #(
        .KEY_NUM    (KN),
        .CNT_MAX    (CM),
        .LONG_MAX   (LM),
        .ACTIVE_LOW (1)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .key_in      (key_in),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long),
        .key_state   (key_state)
    );

    always #5 sys_clk = ~sys_clk;

    // Reference model: the press/release decision depends on how many consecutive
    // clock samples have disagreed with the accepted level. A new level is
    // accepted once CM+1 consecutive disagreeing samples have been seen, because
    // the entry sample is followed by CM window samples. The 2-flop
    // synchroniser is modelled as a two-sample delay. The long press fires on the
    // LM-th edge after acceptance that had no release pending.
    bit  pipe1 [KN];
    bit  pipe2 [KN];
    bit  level [KN];
    int  run   [KN];
    int  held  [KN];
    bit  fired [KN];
    bit  rm;
    logic [KN-1:0] e_press, e_rel, e_long, e_state;

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int c = 0; c < KN; c++) begin
                pipe1[c] = 0; pipe2[c] = 0; level[c] = 0;
                run[c] = 0; held[c] = 0; fired[c] = 0;
            end
            e_press = '0; e_rel = '0; e_long = '0; e_state = '0;
        end else begin
            for (int c = 0; c < KN; c++) begin
                rm = pipe2[c];
                e_press[c] = 0; e_rel[c] = 0; e_long[c] = 0;
                if (!level[c]) begin
                    run[c] = rm ? run[c] + 1 : 0;
                    if (run[c] == CM + 1) begin
                        e_press[c] = 1; level[c] = 1; run[c] = 0;
                        held[c] = 0; fired[c] = 0;
                    end
                end else begin
                    if (run[c] == 0) begin
                        held[c]++;
                        if (held[c] == LM && !fired[c]) begin
                            e_long[c] = 1; fired[c] = 1;
                        end
                    end
                    run[c] = !rm ? run[c] + 1 : 0;
                    if (run[c] == CM + 1) begin
                        e_rel[c] = 1; level[c] = 0; run[c] = 0;
                    end
                end
                pipe2[c] = pipe1[c];
                pipe1[c] = ~key_in[c];
                e_state[c] = level[c];
            end
        end
    end

    task automatic idle_cycles(input int n);
        key_in = '1;
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic test_reset;
        sys_rst_n = 1'b0;
        key_in = '1;
        repeat (3) @(negedge sys_clk);
        checks++;
        if ({key_press, key_release, key_long, key_state} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs got %b want 00000000",
                     {key_press, key_release, key_long, key_state});
        end
        sys_rst_n = 1'b1;
        repeat (4) @(negedge sys_clk);
        checks++;
        if ({key_press, key_release, key_long, key_state} !== 8'h00) begin
            errors++;
            $display("FAIL reset_idle got %b want 00000000",
                     {key_press, key_release, key_long, key_state});
        end
    endtask

    task automatic test_clean_press;
        int first = -1;
        int np = 0;
        key_in[0] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge sys_clk);
            checks++;
            if ({key_press, key_release, key_long, key_state} !== {e_press, e_rel, e_long, e_state}) begin
                errors++;
                $display("FAIL clean_press_cycle k=%0d got %b want %b", k,
                         {key_press, key_release, key_long, key_state}, {e_press, e_rel, e_long, e_state});
            end
            if (key_press[0]) begin np++; if (first < 0) first = k; end
        end
        checks++;
        if (first != 6) begin errors++; $display("FAIL clean_press_latency got %0d want 6", first); end
        checks++;
        if (np != 1) begin errors++; $display("FAIL clean_press_count got %0d want 1", np); end
        checks++;
        if (key_state !== 2'b01) begin errors++; $display("FAIL clean_press_state got %b want 01", key_state); end
        idle_cycles(12);
    endtask

    task automatic test_bounce;
        int first = -1;
        for (int k = 0; k < 16; k++) begin
            key_in[0] = (k == 3) ? 1'b1 : 1'b0;
            @(negedge sys_clk);
            checks++;
            if ({key_press, key_release, key_long, key_state} !== {e_press, e_rel, e_long, e_state}) begin
                errors++;
                $display("FAIL bounce_cycle k=%0d got %b want %b", k,
                         {key_press, key_release, key_long, key_state}, {e_press, e_rel, e_long, e_state});
            end
            if (key_press[0] && first < 0) first = k;
        end
        checks++;
        if (first != 10) begin errors++; $display("FAIL bounce_latency got %0d want 10", first); end
        idle_cycles(12);
    endtask

    task automatic test_long_hold;
        int fp = -1, fl = -1, np = 0, nl = 0;
        key_in[0] = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge sys_clk);
            checks++;
            if ({key_press, key_release, key_long, key_state} !== {e_press, e_rel, e_long, e_state}) begin
                errors++;
                $display("FAIL long_hold_cycle k=%0d got %b want %b", k,
                         {key_press, key_release, key_long, key_state}, {e_press, e_rel, e_long, e_state});
            end
            if (key_press[0]) begin np++; fp = k; end
            if (key_long[0]) begin nl++; fl = k; end
        end
        checks++;
        if (np != 1 || nl != 1) begin
            errors++; $display("FAIL long_hold_counts got press=%0d long=%0d want 1 1", np, nl);
        end
        checks++;
        if (fl - fp != LM) begin errors++; $display("FAIL long_hold_delay got %0d want %0d", fl - fp, LM); end
        idle_cycles(12);
    endtask

    task automatic test_short_press;
        int fr = -1, nl = 0;
        bit bad_state = 0;
        key_in[0] = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (k == 12) key_in[0] = 1'b1;
            @(negedge sys_clk);
            checks++;
            if ({key_press, key_release, key_long, key_state} !== {e_press, e_rel, e_long, e_state}) begin
                errors++;
                $display("FAIL short_press_cycle k=%0d got %b want %b", k,
                         {key_press, key_release, key_long, key_state}, {e_press, e_rel, e_long, e_state});
            end
            if (key_long[0]) nl++;
            if (key_release[0] && fr < 0) begin
                fr = k;
                if (key_state[0] !== 1'b0) bad_state = 1;
            end
        end
        checks++;
        if (fr != 18) begin errors++; $display("FAIL short_release_latency got %0d want 18", fr); end
        checks++;
        if (nl != 0) begin errors++; $display("FAIL short_no_long got %0d want 0", nl); end
        checks++;
        if (bad_state) begin errors++; $display("FAIL short_release_state got 1 want 0"); end
        idle_cycles(4);
    endtask

    task automatic test_reset_mid_debounce;
        int first = -1, nr = 0;
        key_in[0] = 1'b0;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        checks++;
        if ({key_press, key_release, key_long, key_state} !== 8'h00) begin
            errors++;
            $display("FAIL reset_async got %b want 00000000", {key_press, key_release, key_long, key_state});
        end
        repeat (2) @(negedge sys_clk);
        checks++;
        if ({key_press, key_release, key_long, key_state} !== 8'h00) begin
            errors++;
            $display("FAIL reset_hold got %b want 00000000", {key_press, key_release, key_long, key_state});
        end
        sys_rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge sys_clk);
            if (key_press[0] && first < 0) first = k;
            if (key_release[0]) nr++;
        end
        checks++;
        if (first != 6) begin errors++; $display("FAIL reset_repress_latency got %0d want 6", first); end
        checks++;
        if (nr != 0) begin errors++; $display("FAIL reset_no_release got %0d want 0", nr); end
        idle_cycles(12);
    endtask

    task automatic test_concurrent;
        int f0 = -1, f1 = -1, n0 = 0, n1 = 0;
        key_in[0] = 1'b0;
        for (int k = 0; k < 14; k++) begin
            @(negedge sys_clk);
            key_in[1] = 1'b0;
            checks++;
            if ({key_press, key_release, key_long, key_state} !== {e_press, e_rel, e_long, e_state}) begin
                errors++;
                $display("FAIL concurrent_cycle k=%0d got %b want %b", k,
                         {key_press, key_release, key_long, key_state}, {e_press, e_rel, e_long, e_state});
            end
            if (key_press[0]) begin n0++; if (f0 < 0) f0 = k; end
            if (key_press[1]) begin n1++; if (f1 < 0) f1 = k; end
        end
        checks++;
        if (f0 != 6 || f1 != 7) begin
            errors++; $display("FAIL concurrent_latency got %0d %0d want 6 7", f0, f1);
        end
        checks++;
        if (n0 != 1 || n1 != 1) begin
            errors++; $display("FAIL concurrent_counts got %0d %0d want 1 1", n0, n1);
        end
        idle_cycles(12);
    endtask

    task automatic test_random;
        int remain [KN];
        int bad = 0;
        for (int c = 0; c < KN; c++) remain[c] = 0;
        for (int k = 0; k < 900; k++) begin
            for (int c = 0; c < KN; c++) begin
                if (remain[c] == 0) begin
                    key_in[c] = ~key_in[c];
                    remain[c] = ($urandom_range(0, 9) < 7) ? $urandom_range(1, 6)
                                                            : $urandom_range(6, 22);
                end
                remain[c]--;
            end
            sys_rst_n = (k >= 450 && k < 452) ? 1'b0 : 1'b1;
            @(negedge sys_clk);
            checks++;
            if ({key_press, key_release, key_long, key_state} !== {e_press, e_rel, e_long, e_state}) begin
                errors++;
                bad++;
                if (bad < 10)
                    $display("FAIL random_cycle k=%0d got %b want %b", k,
                             {key_press, key_release, key_long, key_state}, {e_press, e_rel, e_long, e_state});
            end
        end
        sys_rst_n = 1'b1;
        idle_cycles(12);
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_hold();
        test_short_press();
        test_reset_mid_debounce();
        test_concurrent();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
